// File: rtl/idex_if.sv
// ID/EX boundary bundle: decoded ID operands/control in, registered EX copies and hazard status out.
interface idex_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 3
);
  logic              id_valid;
  logic [REG_W-1:0]  rx_id, ry_id, rz_id;
  logic              rx_used, ry_used;
  logic [DATA_W-1:0] rx_data, ry_data, imm, pc;
  logic              reg_write, mem_read, mem_write, write_spec_reg, read_spec_reg;
  logic [REG_W-1:0]  dest_id;
  logic [3:0]        alu_op;
  logic              flush_ex;

  logic [REG_W-1:0]  rx_id_idex, ry_id_idex, rz_id_idex;
  logic [DATA_W-1:0] rx_data_idex, ry_data_idex, imm_idex, pc_idex;
  logic              reg_write_idex, mem_read_idex, mem_write_idex;
  logic              write_spec_reg_idex, read_spec_reg_idex;
  logic [REG_W-1:0]  dest_id_idex;
  logic [3:0]        alu_op_idex;
  logic              valid_idex;
  logic              stall_if;
  logic [15:0]       stall_cnt;

  modport master (
    output id_valid, rx_id, ry_id, rz_id, rx_used, ry_used, rx_data, ry_data, imm, pc,
           reg_write, mem_read, mem_write, write_spec_reg, read_spec_reg, dest_id, alu_op,
           flush_ex,
    input  rx_id_idex, ry_id_idex, rz_id_idex, rx_data_idex, ry_data_idex, imm_idex, pc_idex,
           reg_write_idex, mem_read_idex, mem_write_idex, write_spec_reg_idex,
           read_spec_reg_idex, dest_id_idex, alu_op_idex, valid_idex, stall_if, stall_cnt
  );

  modport slave (
    input  id_valid, rx_id, ry_id, rz_id, rx_used, ry_used, rx_data, ry_data, imm, pc,
           reg_write, mem_read, mem_write, write_spec_reg, read_spec_reg, dest_id, alu_op,
           flush_ex,
    output rx_id_idex, ry_id_idex, rz_id_idex, rx_data_idex, ry_data_idex, imm_idex, pc_idex,
           reg_write_idex, mem_read_idex, mem_write_idex, write_spec_reg_idex,
           read_spec_reg_idex, dest_id_idex, alu_op_idex, valid_idex, stall_if, stall_cnt
  );
endinterface

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use hazard detection and one-cycle bubble insertion.
// Optional load-use stall counter enabled by defining IDEX_STALL_CNT_EN.
module idex_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 3
) (
  input logic   clk,
  input logic   rst,
  idex_if.slave bus
);

  typedef enum logic [0:0] {StRun, StStall} state_e;

  state_e            state_q;
  logic [REG_W-1:0]  rx_id_q, ry_id_q, rz_id_q, dest_id_q;
  logic [DATA_W-1:0] rx_data_q, ry_data_q, imm_q, pc_q;
  logic [3:0]        alu_op_q;
  logic              valid_q, reg_write_q, mem_read_q, mem_write_q;
  logic              write_spec_reg_q, read_spec_reg_q;
  logic              rx_hit, ry_hit, hz, stall_if;

  // Only a valid load that writes a register can create a load-use hazard.
  always_comb begin
    rx_hit   = bus.rx_used && (bus.rx_id == dest_id_q);
    ry_hit   = bus.ry_used && (bus.ry_id == dest_id_q);
    hz       = (state_q == StRun) && valid_q && mem_read_q && reg_write_q && bus.id_valid &&
               (rx_hit || ry_hit);
    stall_if = hz && !bus.flush_ex;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StRun;
      valid_q          <= 1'b0;
      reg_write_q      <= 1'b0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      write_spec_reg_q <= 1'b0;
      read_spec_reg_q  <= 1'b0;
      rx_id_q          <= '0;
      ry_id_q          <= '0;
      rz_id_q          <= '0;
      dest_id_q        <= '0;
      rx_data_q        <= '0;
      ry_data_q        <= '0;
      imm_q            <= '0;
      pc_q             <= '0;
      alu_op_q         <= '0;
    end else if (bus.flush_ex || stall_if) begin
      // Bubble: kill every enable, leave data/id fields as they were.
      state_q          <= bus.flush_ex ? StRun : StStall;
      valid_q          <= 1'b0;
      reg_write_q      <= 1'b0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      write_spec_reg_q <= 1'b0;
      read_spec_reg_q  <= 1'b0;
    end else begin
      state_q          <= StRun;
      valid_q          <= bus.id_valid;
      reg_write_q      <= bus.reg_write;
      mem_read_q       <= bus.mem_read;
      mem_write_q      <= bus.mem_write;
      write_spec_reg_q <= bus.write_spec_reg;
      read_spec_reg_q  <= bus.read_spec_reg;
      rx_id_q          <= bus.rx_id;
      ry_id_q          <= bus.ry_id;
      rz_id_q          <= bus.rz_id;
      dest_id_q        <= bus.dest_id;
      rx_data_q        <= bus.rx_data;
      ry_data_q        <= bus.ry_data;
      imm_q            <= bus.imm;
      pc_q             <= bus.pc;
      alu_op_q         <= bus.alu_op;
    end
  end

  assign bus.valid_idex          = valid_q;
  assign bus.reg_write_idex      = reg_write_q;
  assign bus.mem_read_idex       = mem_read_q;
  assign bus.mem_write_idex      = mem_write_q;
  assign bus.write_spec_reg_idex = write_spec_reg_q;
  assign bus.read_spec_reg_idex  = read_spec_reg_q;
  assign bus.rx_id_idex          = rx_id_q;
  assign bus.ry_id_idex          = ry_id_q;
  assign bus.rz_id_idex          = rz_id_q;
  assign bus.dest_id_idex        = dest_id_q;
  assign bus.rx_data_idex        = rx_data_q;
  assign bus.ry_data_idex        = ry_data_q;
  assign bus.imm_idex            = imm_q;
  assign bus.pc_idex             = pc_q;
  assign bus.alu_op_idex         = alu_op_q;
  assign bus.stall_if            = stall_if;

`ifdef IDEX_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall_if && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_idex_stage.sv
// Table-driven bench for idex_stage; post-edge expectations queued at drive time, popped after the edge.
module tb_idex_stage;

  logic clk = 1'b0;
  logic rst;

  idex_if #(.DATA_W(16), .REG_W(3)) bus ();

  idex_stage #(.DATA_W(16), .REG_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        idv;
    logic [2:0]  rx_id;
    logic        rxu;
    logic [2:0]  ry_id;
    logic        ryu;
    logic [15:0] rx_data;
    logic [3:0]  alu;
    logic [2:0]  dest;
    logic        rw;
    logic        mr;
    logic        fl;
    logic [15:0] pc;
    logic        e_stall;
    logic        e_valid;
    logic [15:0] e_rx;
    logic [3:0]  e_alu;
    logic [2:0]  e_dest;
    logic        e_rw;
    logic        e_mr;
    logic [15:0] e_pc;
    logic [15:0] e_cnt;
  } vec_t;

  typedef struct {
    logic        chk_derived;
    logic        valid;
    logic [15:0] rx;
    logic [3:0]  alu;
    logic [2:0]  dest;
    logic        rw;
    logic        mr;
    logic [15:0] pc;
    logic [15:0] cnt;
  } exp_t;

  vec_t vecs[25];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic cnt_en;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst                = v.rst;
    bus.id_valid       = v.idv;
    bus.rx_id          = v.rx_id;
    bus.rx_used        = v.rxu;
    bus.ry_id          = v.ry_id;
    bus.ry_used        = v.ryu;
    bus.rz_id          = v.rx_id;
    bus.rx_data        = v.rx_data;
    bus.ry_data        = v.rx_data ^ 16'hFFFF;
    bus.imm            = v.pc + 16'd1;
    bus.pc             = v.pc;
    bus.alu_op         = v.alu;
    bus.dest_id        = v.dest;
    bus.reg_write      = v.rw;
    bus.mem_read       = v.mr;
    bus.mem_write      = v.rw & ~v.mr;
    bus.write_spec_reg = v.mr;
    bus.read_spec_reg  = v.mr;
    bus.flush_ex       = v.fl;
  endtask

  initial begin
`ifdef IDEX_STALL_CNT_EN
    cnt_en = 1'b1;
`else
    cnt_en = 1'b0;
`endif
    //        rst idv rx rxu ry ryu rx_data  alu dst rw mr fl pc     | st v  e_rx    alu dst rw mr e_pc   cnt
    vecs[0]  = '{0, 1, 1, 1, 0, 0, 16'h1234, 5, 1, 1, 0, 0, 16'h10,  0, 1, 16'h1234, 5, 1, 1, 0, 16'h10, 0};
    vecs[1]  = '{0, 1, 2, 1, 0, 0, 16'h2222, 0, 3, 1, 1, 0, 16'h12,  0, 1, 16'h2222, 0, 3, 1, 1, 16'h12, 0};
    vecs[2]  = '{0, 1, 3, 1, 0, 0, 16'h3333, 2, 4, 1, 0, 0, 16'h14,  1, 0, 16'h2222, 0, 3, 0, 0, 16'h12, 1};
    vecs[3]  = '{0, 1, 3, 1, 0, 0, 16'h3333, 2, 4, 1, 0, 0, 16'h14,  0, 1, 16'h3333, 2, 4, 1, 0, 16'h14, 1};
    vecs[4]  = '{0, 1, 0, 1, 0, 0, 16'h4444, 1, 5, 1, 1, 0, 16'h16,  0, 1, 16'h4444, 1, 5, 1, 1, 16'h16, 1};
    vecs[5]  = '{0, 1, 5, 0, 6, 1, 16'h5555, 3, 6, 1, 1, 0, 16'h18,  0, 1, 16'h5555, 3, 6, 1, 1, 16'h18, 1};
    vecs[6]  = '{0, 1, 6, 0, 6, 1, 16'h6666, 4, 7, 1, 0, 0, 16'h1A,  1, 0, 16'h5555, 3, 6, 0, 0, 16'h18, 2};
    vecs[7]  = '{0, 1, 6, 0, 6, 1, 16'h6666, 4, 7, 1, 0, 0, 16'h1A,  0, 1, 16'h6666, 4, 7, 1, 0, 16'h1A, 2};
    vecs[8]  = '{0, 1, 0, 1, 0, 0, 16'h8888, 0, 1, 1, 1, 0, 16'h1C,  0, 1, 16'h8888, 0, 1, 1, 1, 16'h1C, 2};
    vecs[9]  = '{0, 1, 1, 1, 0, 0, 16'h9999, 0, 2, 1, 1, 0, 16'h1E,  1, 0, 16'h8888, 0, 1, 0, 0, 16'h1C, 3};
    vecs[10] = '{0, 1, 1, 1, 0, 0, 16'h9999, 0, 2, 1, 1, 0, 16'h1E,  0, 1, 16'h9999, 0, 2, 1, 1, 16'h1E, 3};
    vecs[11] = '{0, 1, 2, 1, 0, 0, 16'hBBBB, 6, 3, 1, 0, 0, 16'h20,  1, 0, 16'h9999, 0, 2, 0, 0, 16'h1E, 4};
    vecs[12] = '{0, 1, 2, 1, 0, 0, 16'hBBBB, 6, 3, 1, 0, 0, 16'h20,  0, 1, 16'hBBBB, 6, 3, 1, 0, 16'h20, 4};
    vecs[13] = '{0, 1, 0, 1, 0, 0, 16'hCCCC, 1, 4, 1, 1, 0, 16'h22,  0, 1, 16'hCCCC, 1, 4, 1, 1, 16'h22, 4};
    // hazard and flush together: flush wins, no stall, no count
    vecs[14] = '{0, 1, 4, 1, 0, 0, 16'hDDDD, 2, 5, 1, 0, 1, 16'h24,  0, 0, 16'hCCCC, 1, 4, 0, 0, 16'h22, 4};
    vecs[15] = '{0, 1, 0, 1, 0, 0, 16'hEEEE, 3, 6, 1, 1, 0, 16'h26,  0, 1, 16'hEEEE, 3, 6, 1, 1, 16'h26, 4};
    vecs[16] = '{0, 0, 6, 1, 0, 0, 16'hFFFF, 4, 7, 1, 0, 0, 16'h28,  0, 0, 16'hFFFF, 4, 7, 1, 0, 16'h28, 4};
    vecs[17] = '{0, 1, 0, 1, 0, 0, 16'h1111, 5, 2, 1, 1, 0, 16'h2A,  0, 1, 16'h1111, 5, 2, 1, 1, 16'h2A, 4};
    vecs[18] = '{0, 1, 2, 1, 0, 0, 16'h2020, 6, 3, 1, 0, 0, 16'h2C,  1, 0, 16'h1111, 5, 2, 0, 0, 16'h2A, 5};
    // reset during the stall cycle, then capture with no extra bubble
    vecs[19] = '{1, 1, 2, 1, 0, 0, 16'h2020, 6, 3, 1, 0, 0, 16'h2C,  0, 0, 16'h0000, 0, 0, 0, 0, 16'h00, 0};
    vecs[20] = '{0, 1, 2, 1, 0, 0, 16'h2020, 6, 3, 1, 0, 0, 16'h2C,  0, 1, 16'h2020, 6, 3, 1, 0, 16'h2C, 0};
    vecs[21] = '{0, 1, 0, 1, 0, 0, 16'h3030, 7, 4, 1, 1, 0, 16'h2E,  0, 1, 16'h3030, 7, 4, 1, 1, 16'h2E, 0};
    vecs[22] = '{0, 1, 4, 1, 0, 0, 16'h4040, 8, 5, 1, 0, 0, 16'h30,  1, 0, 16'h3030, 7, 4, 0, 0, 16'h2E, 1};
    // flush arriving in the stall cycle
    vecs[23] = '{0, 1, 4, 1, 0, 0, 16'h4040, 8, 5, 1, 0, 1, 16'h30,  0, 0, 16'h3030, 7, 4, 0, 0, 16'h2E, 1};
    vecs[24] = '{0, 1, 4, 1, 0, 0, 16'h4040, 8, 5, 1, 0, 0, 16'h30,  0, 1, 16'h4040, 8, 5, 1, 0, 16'h30, 1};

    // Reset held two cycles with arbitrary ID inputs
    drive(vecs[1]);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset valid_idex",     {15'd0, bus.valid_idex},     16'h0);
    chk("reset stall_if",       {15'd0, bus.stall_if},       16'h0);
    chk("reset reg_write_idex", {15'd0, bus.reg_write_idex}, 16'h0);
    chk("reset mem_read_idex",  {15'd0, bus.mem_read_idex},  16'h0);
    chk("reset rx_data_idex",   bus.rx_data_idex,            16'h0);
    chk("reset pc_idex",        bus.pc_idex,                 16'h0);
    chk("reset dest_id_idex",   {13'd0, bus.dest_id_idex},   16'h0);
    chk("reset stall_cnt",      bus.stall_cnt,               16'h0);

    for (int i = 0; i < 25; i++) begin
      exp_t e;
      vec_t v;
      v = vecs[i];
      drive(v);
      #1;
      chk($sformatf("v%0d stall_if", i), {15'd0, bus.stall_if}, {15'd0, v.e_stall});
      e.chk_derived = !v.rst;
      e.valid       = v.e_valid;
      e.rx          = v.e_rx;
      e.alu         = v.e_alu;
      e.dest        = v.e_dest;
      e.rw          = v.e_rw;
      e.mr          = v.e_mr;
      e.pc          = v.e_pc;
      e.cnt         = cnt_en ? v.e_cnt : 16'h0;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d valid_idex", i),     {15'd0, bus.valid_idex},     {15'd0, e.valid});
      chk($sformatf("v%0d rx_data_idex", i),   bus.rx_data_idex,            e.rx);
      chk($sformatf("v%0d alu_op_idex", i),    {12'd0, bus.alu_op_idex},    {12'd0, e.alu});
      chk($sformatf("v%0d dest_id_idex", i),   {13'd0, bus.dest_id_idex},   {13'd0, e.dest});
      chk($sformatf("v%0d reg_write_idex", i), {15'd0, bus.reg_write_idex}, {15'd0, e.rw});
      chk($sformatf("v%0d mem_read_idex", i),  {15'd0, bus.mem_read_idex},  {15'd0, e.mr});
      chk($sformatf("v%0d mem_write_idex", i), {15'd0, bus.mem_write_idex},
          {15'd0, e.rw & ~e.mr});
      chk($sformatf("v%0d spec_idex", i),
          {14'd0, bus.write_spec_reg_idex, bus.read_spec_reg_idex}, {14'd0, e.mr, e.mr});
      chk($sformatf("v%0d pc_idex", i),        bus.pc_idex,                 e.pc);
      chk($sformatf("v%0d stall_cnt", i),      bus.stall_cnt,               e.cnt);
      if (e.chk_derived) begin
        chk($sformatf("v%0d ry_data_idex", i), bus.ry_data_idex, e.rx ^ 16'hFFFF);
        chk($sformatf("v%0d imm_idex", i),     bus.imm_idex,     e.pc + 16'd1);
        chk($sformatf("v%0d rx_id_idex", i),   {13'd0, bus.rx_id_idex}, {13'd0, bus.rz_id_idex});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
